// File: rtl/rc4_prga_decrypt_if.sv
// RC4 PRGA bus bundle: start/status, S RAM port, encrypted ROM port, decrypted RAM port.
// master = PRGA engine side, slave = memories / controller side.
interface rc4_prga_decrypt_if;
  logic       sig_start;
  logic [7:0] s_rdata;
  logic [7:0] s_addr;
  logic [7:0] s_wdata;
  logic       s_we;
  logic [7:0] enc_data;
  logic [7:0] enc_addr;
  logic [7:0] dec_addr;
  logic [7:0] dec_data;
  logic       dec_we;
  logic       t_done;
  logic       t_bad;

  modport master (
    input  sig_start, s_rdata, enc_data,
    output s_addr, s_wdata, s_we,
    output enc_addr, dec_addr, dec_data, dec_we,
    output t_done, t_bad
  );

  modport slave (
    output sig_start, s_rdata, enc_data,
    input  s_addr, s_wdata, s_we,
    input  enc_addr, dec_addr, dec_data, dec_we,
    input  t_done, t_bad
  );
endinterface

// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA: walks the KSA-shuffled S RAM, XORs keystream with the encrypted ROM,
// writes plaintext to the decrypted RAM and flags bytes outside 'a'..'z'/space.
// Ports: clk, reset (sync, active-high), io (rc4_prga_decrypt_if.master).
module rc4_prga_decrypt #(
  parameter int MSG_LEN   = 32,
  parameter int READ_WAIT = 3,
  parameter int CHECK_EN  = 1
) (
  input  logic clk,
  input  logic reset,
  rc4_prga_decrypt_if.master io
);

  typedef enum logic [4:0] {
    IDLE, INIT, RD_I, WAIT_I, CAP_I, CALC_J,
    RD_J, WAIT_J, CAP_J, WR_I, WR_J, RD_F,
    WAIT_F, CAP_F, CHECK, WR_D, NEXT, DONE
  } state_t;

  localparam logic [7:0] LAST  = 8'(MSG_LEN - 1);
  localparam logic [7:0] W_END = 8'(READ_WAIT - 1);

  state_t     state_q, state_d;
  logic [7:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [7:0] si_q, si_d, sj_q, sj_d;
  logic [7:0] f_q, f_d, e_q, e_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] s_addr_q, s_addr_d;
  logic [7:0] s_wdata_q, s_wdata_d;
  logic       s_we_q, s_we_d;
  logic [7:0] enc_addr_q, enc_addr_d;
  logic [7:0] dec_addr_q, dec_addr_d;
  logic [7:0] dec_data_q, dec_data_d;
  logic       dec_we_q, dec_we_d;
  logic       t_done_q, t_done_d;
  logic       t_bad_q, t_bad_d;

  logic [7:0] pt;
  logic       pt_ok;
  logic       wait_end;

  assign pt       = f_q ^ e_q;
  assign pt_ok    = (pt >= 8'h61 && pt <= 8'h7a)
                 || (pt == 8'h20);
  assign wait_end = (cnt_q == W_END);

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    si_d       = si_q;
    sj_d       = sj_q;
    f_d        = f_q;
    e_d        = e_q;
    cnt_d      = cnt_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    s_we_d     = 1'b0;
    enc_addr_d = enc_addr_q;
    dec_addr_d = dec_addr_q;
    dec_data_d = dec_data_q;
    dec_we_d   = 1'b0;
    t_done_d   = 1'b0;
    t_bad_d    = t_bad_q;
    unique case (state_q)
      IDLE: if (io.sig_start) state_d = INIT;
      INIT: begin
        i_d     = 8'd0;
        j_d     = 8'd0;
        k_d     = 8'd0;
        t_bad_d = 1'b0;
        state_d = RD_I;
      end
      RD_I: begin
        i_d      = i_q + 8'd1;
        s_addr_d = i_q + 8'd1;
        cnt_d    = 8'd0;
        state_d  = WAIT_I;
      end
      WAIT_I: begin
        if (wait_end) state_d = CAP_I;
        else          cnt_d   = cnt_q + 8'd1;
      end
      CAP_I: begin
        si_d    = io.s_rdata;
        state_d = CALC_J;
      end
      CALC_J: begin
        j_d     = j_q + si_q;
        state_d = RD_J;
      end
      RD_J: begin
        s_addr_d = j_q;
        cnt_d    = 8'd0;
        state_d  = WAIT_J;
      end
      WAIT_J: begin
        if (wait_end) state_d = CAP_J;
        else          cnt_d   = cnt_q + 8'd1;
      end
      CAP_J: begin
        sj_d    = io.s_rdata;
        state_d = WR_I;
      end
      WR_I: begin
        s_addr_d  = i_q;
        s_wdata_d = sj_q;
        s_we_d    = 1'b1;
        state_d   = WR_J;
      end
      WR_J: begin
        s_addr_d  = j_q;
        s_wdata_d = si_q;
        s_we_d    = 1'b1;
        state_d   = RD_F;
      end
      RD_F: begin
        s_addr_d   = si_q + sj_q;
        enc_addr_d = k_q;
        cnt_d      = 8'd0;
        state_d    = WAIT_F;
      end
      WAIT_F: begin
        if (wait_end) state_d = CAP_F;
        else          cnt_d   = cnt_q + 8'd1;
      end
      CAP_F: begin
        f_d     = io.s_rdata;
        e_d     = io.enc_data;
        state_d = CHECK;
      end
      CHECK: begin
        if (!pt_ok && CHECK_EN != 0) begin
          t_bad_d = 1'b1;
          state_d = DONE;
        end else begin
          state_d = WR_D;
        end
      end
      WR_D: begin
        dec_addr_d = k_q;
        dec_data_d = pt;
        dec_we_d   = 1'b1;
        state_d    = NEXT;
      end
      NEXT: begin
        if (k_q == LAST) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + 8'd1;
          state_d = RD_I;
        end
      end
      DONE: begin
        t_done_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      i_q        <= 8'd0;
      j_q        <= 8'd0;
      k_q        <= 8'd0;
      si_q       <= 8'd0;
      sj_q       <= 8'd0;
      f_q        <= 8'd0;
      e_q        <= 8'd0;
      cnt_q      <= 8'd0;
      s_addr_q   <= 8'd0;
      s_wdata_q  <= 8'd0;
      s_we_q     <= 1'b0;
      enc_addr_q <= 8'd0;
      dec_addr_q <= 8'd0;
      dec_data_q <= 8'd0;
      dec_we_q   <= 1'b0;
      t_done_q   <= 1'b0;
      t_bad_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      si_q       <= si_d;
      sj_q       <= sj_d;
      f_q        <= f_d;
      e_q        <= e_d;
      cnt_q      <= cnt_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      s_we_q     <= s_we_d;
      enc_addr_q <= enc_addr_d;
      dec_addr_q <= dec_addr_d;
      dec_data_q <= dec_data_d;
      dec_we_q   <= dec_we_d;
      t_done_q   <= t_done_d;
      t_bad_q    <= t_bad_d;
    end
  end

  assign io.s_addr   = s_addr_q;
  assign io.s_wdata  = s_wdata_q;
  assign io.s_we     = s_we_q;
  assign io.enc_addr = enc_addr_q;
  assign io.dec_addr = dec_addr_q;
  assign io.dec_data = dec_data_q;
  assign io.dec_we   = dec_we_q;
  assign io.t_done   = t_done_q;
  assign io.t_bad    = t_bad_q;

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Testbench for rc4_prga_decrypt: registered-read memory models around the DUT,
// software RC4 PRGA reference, directed and randomized runs.
module tb_rc4_prga_decrypt;
  localparam int N = 32;

  logic clk = 1'b0;
  logic reset;
  logic load;
  always #5 clk = ~clk;

  rc4_prga_decrypt_if bus();

  rc4_prga_decrypt #(
    .MSG_LEN(N), .READ_WAIT(3), .CHECK_EN(1)
  ) dut (
    .clk(clk), .reset(reset), .io(bus)
  );

  logic [7:0]  s_init[256];
  logic [7:0]  enc_init[256];
  logic [7:0]  s_mem[256];
  logic [7:0]  enc_mem[256];
  logic [7:0]  dec_mem[256];
  logic [15:0] s_log[$];
  logic [15:0] d_log[$];
  int          done_cnt;
  int          both_cnt;

  always @(posedge clk) begin
    if (load) begin
      s_mem   <= s_init;
      enc_mem <= enc_init;
      for (int a = 0; a < 256; a++) dec_mem[a] <= 8'h00;
      s_log.delete();
      d_log.delete();
      done_cnt <= 0;
      both_cnt <= 0;
    end else begin
      if (bus.s_we) begin
        s_mem[bus.s_addr] <= bus.s_wdata;
        s_log.push_back({bus.s_addr, bus.s_wdata});
      end
      if (bus.dec_we) begin
        dec_mem[bus.dec_addr] <= bus.dec_data;
        d_log.push_back({bus.dec_addr, bus.dec_data});
      end
      if (bus.t_done) done_cnt <= done_cnt + 1;
      if (bus.s_we && bus.dec_we) both_cnt <= both_cnt + 1;
    end
    bus.s_rdata  <= s_mem[bus.s_addr];
    bus.enc_data <= enc_mem[bus.enc_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [7:0]  exp_s[256];
  logic [15:0] exp_w[$];
  logic [15:0] exp_d[$];
  logic        exp_bad;
  logic [7:0]  ks[N];

  function automatic bit valid_ch(logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7a) || c == 8'h20;
  endfunction

  // Plain RC4 PRGA over an array; nocheck=1 just produces the keystream.
  task automatic model(bit nocheck);
    logic [7:0] i, j, si, sj, f, p;
    exp_s = s_init;
    exp_w.delete();
    exp_d.delete();
    exp_bad = 1'b0;
    i = 8'd0;
    j = 8'd0;
    for (int k = 0; k < N; k++) begin
      i = i + 8'd1;
      si = exp_s[i];
      j = j + si;
      sj = exp_s[j];
      exp_s[i] = sj;
      exp_s[j] = si;
      exp_w.push_back({i, sj});
      exp_w.push_back({j, si});
      f = exp_s[8'(si + sj)];
      ks[k] = f;
      p = f ^ enc_init[k];
      if (nocheck || valid_ch(p)) begin
        exp_d.push_back({8'(k), p});
      end else begin
        exp_bad = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [7:0] rnd_pt();
    int r;
    r = $urandom_range(0, 26);
    return (r == 26) ? 8'h20 : 8'(8'h61 + r);
  endfunction

  task automatic s_ident();
    for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
  endtask

  // keystream from current s_init, then encrypt random valid text
  task automatic fill_pt();
    model(1'b1);
    for (int a = 0; a < 256; a++) enc_init[a] = 8'($urandom);
    for (int k = 0; k < N; k++) enc_init[k] = ks[k] ^ rnd_pt();
  endtask

  task automatic load_mem();
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
  endtask

  task automatic wait_done(string tag, int target);
    int c;
    c = 0;
    while (done_cnt < target && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk({tag, " done_seen"}, 64'(done_cnt >= target), 64'd1);
  endtask

  task automatic check_run(string tag);
    int diff;
    chk({tag, " t_bad"}, 64'(bus.t_bad), 64'(exp_bad));
    chk({tag, " n_swr"}, 64'(s_log.size()), 64'(exp_w.size()));
    chk({tag, " n_dwr"}, 64'(d_log.size()), 64'(exp_d.size()));
    if (s_log.size() == exp_w.size())
      for (int a = 0; a < exp_w.size(); a++)
        chk({tag, " swr"}, 64'(s_log[a]), 64'(exp_w[a]));
    if (d_log.size() == exp_d.size())
      for (int a = 0; a < exp_d.size(); a++)
        chk({tag, " dwr"}, 64'(d_log[a]), 64'(exp_d[a]));
    diff = 0;
    for (int a = 0; a < 256; a++)
      if (s_mem[a] !== exp_s[a]) diff++;
    chk({tag, " s_final_diffs"}, 64'(diff), 64'd0);
    chk({tag, " both_we"}, 64'(both_cnt), 64'd0);
  endtask

  task automatic run(string tag);
    model(1'b0);
    load_mem();
    @(negedge clk) bus.sig_start = 1'b1;
    @(negedge clk) bus.sig_start = 1'b0;
    wait_done(tag, 1);
    check_run(tag);
    repeat (3) @(negedge clk);
    chk({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
  endtask

  task automatic t1_data();
    s_ident();
    fill_pt();
    enc_init[0] = 8'h63;
    enc_init[1] = 8'h64;
    enc_init[2] = 8'h66;
    enc_init[3] = 8'h6c;
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.s_addr, bus.s_wdata, bus.s_we,
                bus.enc_addr, bus.dec_addr, bus.dec_data,
                bus.dec_we, bus.t_done, bus.t_bad});
  endfunction

  initial begin
    int ns, nd;
    logic [7:0] key[3];
    logic [7:0] j8, tmp;
    int p;
    reset = 1'b1;
    load = 1'b0;
    bus.sig_start = 1'b0;
    s_ident();
    for (int a = 0; a < 256; a++) enc_init[a] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 64'd0);
    reset = 1'b0;

    // spec example: identity S, first 4 bytes decrypt to 'aaaa'
    t1_data();
    run("t1");
    chk("t1 wr01", {32'd0, s_log[0], s_log[1]}, 64'h0101_0101);
    chk("t1 wr23", {32'd0, s_log[2], s_log[3]}, 64'h0203_0302);
    chk("t1 wr45", {32'd0, s_log[4], s_log[5]}, 64'h0305_0502);
    chk("t1 wr67", {32'd0, s_log[6], s_log[7]}, 64'h0409_0904);
    chk("t1 dec03", 64'({dec_mem[0], dec_mem[1], dec_mem[2], dec_mem[3]}),
        64'h6161_6161);

    // invalid third byte aborts
    t1_data();
    enc_init[2] = 8'h00;
    run("t2");
    chk("t2 t_bad", 64'(bus.t_bad), 64'd1);
    chk("t2 n_dec", 64'(d_log.size()), 64'd2);

    // j and f index wrap
    s_ident();
    s_init[8'h01] = 8'h90;
    s_init[8'h90] = 8'h80;
    s_init[8'h80] = 8'h01;
    fill_pt();
    enc_init[0] = 8'h71;
    run("t3");
    chk("t3 wr0", 64'(s_log[0]), 64'h0180);
    chk("t3 wr1", 64'(s_log[1]), 64'h9090);
    chk("t3 dec0", 64'(dec_mem[0]), 64'h61);

    // reset mid-run, then rerun bit-exact
    t1_data();
    model(1'b0);
    load_mem();
    @(negedge clk) bus.sig_start = 1'b1;
    @(negedge clk) bus.sig_start = 1'b0;
    repeat ($urandom_range(20, 400)) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t4 reset_outs", outs(), 64'd0);
    reset = 1'b0;
    ns = s_log.size();
    nd = d_log.size();
    repeat (4) @(negedge clk);
    chk("t4 idle_swr", 64'(s_log.size()), 64'(ns));
    chk("t4 idle_dwr", 64'(d_log.size()), 64'(nd));
    run("t4r");

    // start held high: one run, then a fresh restart
    t1_data();
    model(1'b0);
    load_mem();
    @(negedge clk) bus.sig_start = 1'b1;
    wait_done("t5", 1);
    check_run("t5");
    chk("t5 pulses1", 64'(done_cnt), 64'd1);
    @(negedge clk) bus.sig_start = 1'b0;
    wait_done("t5b", 2);
    repeat (3) @(negedge clk);
    chk("t5 pulses2", 64'(done_cnt), 64'd2);

    // KSA with key 00 02 49, full valid message
    key[0] = 8'h00;
    key[1] = 8'h02;
    key[2] = 8'h49;
    s_ident();
    j8 = 8'd0;
    for (int a = 0; a < 256; a++) begin
      j8 = j8 + s_init[a] + key[a % 3];
      tmp = s_init[a];
      s_init[a] = s_init[j8];
      s_init[j8] = tmp;
    end
    fill_pt();
    run("t6");
    chk("t6 t_bad", 64'(bus.t_bad), 64'd0);

    // random permutations, some with an injected bad byte
    for (int r = 0; r < 4; r++) begin
      s_ident();
      for (int a = 255; a > 0; a--) begin
        p = $urandom_range(0, a);
        tmp = s_init[a];
        s_init[a] = s_init[p];
        s_init[p] = tmp;
      end
      fill_pt();
      if (r[0]) begin
        p = $urandom_range(0, N - 1);
        enc_init[p] = ks[p] ^ 8'($urandom_range(0, 31));
      end
      run($sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
